// File: rtl/stack_pkg.sv
// Shared types and constants for the return-address stack sequencer/arbiter.
package stack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

endpackage

// File: rtl/stack_arbiter_ctrl.sv
// Two-requester arbiter and sequencer for the shared return-address stack memory.
//  state | meaning
//  IDLE  | sample requests, r1 has priority; latch grant, op and push data
//  EXEC  | perform memory access or flag overflow/underflow
//  RESP  | one-cycle ack to the granted requester, nak if rejected
//  ERR   | requests ignored until err_clr
module stack_arbiter_ctrl
  import stack_pkg::*;
#(
  parameter  int WIDTH  = 10,
  parameter  int NWORDS = 16,
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_op,
  input  logic [WIDTH-1:0] r0_wdata,
  input  logic             r1_req,
  input  logic             r1_op,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             ack0,
  output logic             ack1,
  output logic             nak,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(NWORDS);

  state_t           state;
  logic             gnt;
  logic             op_q;
  logic [AW-1:0]    sp;

  logic             sel_op;
  logic [WIDTH-1:0] sel_wdata;

  assign sel_op    = r1_req ? r1_op    : r0_op;
  assign sel_wdata = r1_req ? r1_wdata : r0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= REQ_R0;
      op_q      <= OP_PUSH;
      sp        <= '1;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      nak       <= 1'b0;
      rd_data   <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '1;
      mem_wdata <= '0;
    end else begin
      // Clear first so an error raised in EXEC the same cycle still sticks.
      if (err_clr) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            gnt   <= r1_req ? REQ_R1 : REQ_R0;
            op_q  <= sel_op;
            state <= EXEC;
            if (sel_op == OP_PUSH && !full) begin
              mem_we    <= 1'b1;
              mem_addr  <= sp + 1'b1;
              mem_wdata <= sel_wdata;
            end else begin
              mem_addr  <= sp;
            end
          end
        end
        EXEC: begin
          mem_we <= 1'b0;
          if (op_q == OP_PUSH) begin
            if (!full) begin
              sp       <= sp + 1'b1;
              mem_addr <= sp + 1'b1;
              count    <= count + 1'b1;
              full     <= (count + 1'b1) == CNT_MAX;
              empty    <= 1'b0;
            end else begin
              err_ovf <= 1'b1;
              nak     <= 1'b1;
            end
          end else begin
            if (!empty) begin
              rd_data  <= mem_rdata;
              sp       <= sp - 1'b1;
              mem_addr <= sp - 1'b1;
              count    <= count - 1'b1;
              empty    <= count == (AW+1)'(1);
              full     <= 1'b0;
            end else begin
              err_unf <= 1'b1;
              nak     <= 1'b1;
            end
          end
          ack0  <= (gnt == REQ_R0);
          ack1  <= (gnt == REQ_R1);
          state <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          nak   <= 1'b0;
          state <= nak ? ERR : IDLE;
        end
        ERR: begin
          if (err_clr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
